// File: rtl/npc_bpred_unit.sv
// Next-PC unit: owns the fetch PC, a direct-mapped BTB with 2-bit direction
// counters, and the execute-stage redirect that flushes on a mispredict.
module npc_bpred_unit #(
    parameter int              XLEN     = 32,
    parameter int              ENTRIES  = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter bit              PRED_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            res_valid,
    input  logic [1:0]      res_type,
    input  logic [XLEN-1:0] res_pc,
    input  logic            res_taken,
    input  logic [XLEN-1:0] res_target,
    input  logic            res_pred_taken,
    input  logic [XLEN-1:0] res_pred_target,
    output logic            flush,
    output logic [15:0]     mispredict_cnt,
    output logic [15:0]     branch_cnt
);

    localparam int         IDX   = $clog2(ENTRIES);
    localparam int         TAGW  = XLEN - IDX - 2;
    localparam logic [1:0] T_BR  = 2'b00;
    localparam logic [1:0] T_RSV = 2'b11;

    logic             btb_valid  [ENTRIES];
    logic [TAGW-1:0]  btb_tag    [ENTRIES];
    logic [XLEN-1:0]  btb_target [ENTRIES];
    logic [1:0]       btb_type   [ENTRIES];
    logic [1:0]       btb_ctr    [ENTRIES];

    logic [IDX-1:0]   lk_idx;
    logic [TAGW-1:0]  lk_tag;
    logic             lk_hit;
    logic [XLEN-1:0]  pc_plus4;

    logic [IDX-1:0]   up_idx;
    logic [TAGW-1:0]  up_tag;
    logic             up_hit;
    logic             res_live;
    logic             mispredict;
    logic [XLEN-1:0]  correct_pc;
    logic [1:0]       ctr_next;

    // Lookup reads the pre-update array contents; there is no write bypass.
    assign lk_idx      = pc[IDX+1:2];
    assign lk_tag      = pc[XLEN-1:IDX+2];
    assign lk_hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign pc_plus4    = pc + XLEN'(4);
    assign pred_taken  = PRED_EN && lk_hit &&
                         ((btb_type[lk_idx] != T_BR) || btb_ctr[lk_idx][1]);
    assign pred_target = pred_taken ? btb_target[lk_idx] : pc_plus4;

    // Reserved resolve type behaves as if nothing resolved this cycle.
    assign res_live    = res_valid && (res_type != T_RSV);
    assign mispredict  = res_live &&
                         ((res_taken != res_pred_taken) ||
                          (res_taken && (res_target != res_pred_target)));
    assign flush       = mispredict;
    assign correct_pc  = res_taken ? res_target : (res_pc + XLEN'(4));

    assign up_idx      = res_pc[IDX+1:2];
    assign up_tag      = res_pc[XLEN-1:IDX+2];
    assign up_hit      = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);

    // Direction counter value written back on an update or allocation.
    always_comb begin
        ctr_next = btb_ctr[up_idx];
        if (res_type != T_BR) begin
            ctr_next = 2'b11;
        end else if (!up_hit) begin
            ctr_next = 2'b10;
        end else if (res_taken) begin
            ctr_next = (btb_ctr[up_idx] == 2'b11) ? 2'b11 : btb_ctr[up_idx] + 2'd1;
        end else begin
            ctr_next = (btb_ctr[up_idx] == 2'b00) ? 2'b00 : btb_ctr[up_idx] - 2'd1;
        end
    end

    // Fetch PC: redirect beats stall, otherwise follow the prediction.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (mispredict) begin
            pc <= correct_pc;
        end else if (!stall) begin
            pc <= pred_target;
        end
    end

    // BTB training: hits always update, misses allocate only when taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_type[i]   <= T_BR;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (res_live && (up_hit || res_taken)) begin
            btb_valid[up_idx]  <= 1'b1;
            btb_tag[up_idx]    <= up_tag;
            btb_target[up_idx] <= res_target;
            btb_type[up_idx]   <= res_type;
            btb_ctr[up_idx]    <= ctr_next;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (res_live && (branch_cnt != 16'hFFFF)) begin
                branch_cnt <= branch_cnt + 16'd1;
            end
            if (mispredict && (mispredict_cnt != 16'hFFFF)) begin
                mispredict_cnt <= mispredict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_npc_bpred_unit.sv
// Scoreboard bench for npc_bpred_unit: a predicting build and a PRED_EN=0
// build share all inputs; expectations are queued with the cycle they fall due.
module tb_npc_bpred_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        res_valid = 1'b0;
    logic [1:0]  res_type = 2'b00;
    logic [31:0] res_pc = '0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        res_pred_taken = 1'b0;
    logic [31:0] res_pred_target = '0;

    logic [31:0] pc, pred_target, pc0, pred_target0;
    logic        pred_taken, flush, pred_taken0, flush0;
    logic [15:0] mcnt, bcnt, mcnt0, bcnt0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int e_m     = 0;
    int e_b     = 0;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;
    exp_t sb[$];

    npc_bpred_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .pc(pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_type(res_type), .res_pc(res_pc),
        .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .flush(flush), .mispredict_cnt(mcnt), .branch_cnt(bcnt)
    );

    npc_bpred_unit #(.PRED_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .pc(pc0),
        .pred_taken(pred_taken0), .pred_target(pred_target0),
        .res_valid(res_valid), .res_type(res_type), .res_pc(res_pc),
        .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .flush(flush0), .mispredict_cnt(mcnt0), .branch_cnt(bcnt0)
    );

    always #5 clk = ~clk;

    localparam int S_PC = 0, S_PT = 1, S_PTG = 2, S_FL = 3, S_MC = 4, S_BC = 5,
                   S_PT0 = 6, S_PC0 = 7;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_PC:    return pc;
            S_PT:    return {31'd0, pred_taken};
            S_PTG:   return pred_target;
            S_FL:    return {31'd0, flush};
            S_MC:    return {16'd0, mcnt};
            S_BC:    return {16'd0, bcnt};
            S_PT0:   return {31'd0, pred_taken0};
            default: return pc0;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_at(input string tag, input int sel, input int ofs, input logic [31:0] v);
        exp_t e;
        e.due = cyc + ofs;
        e.sel = sel;
        e.exp = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Compare everything due at the falling edge, then advance one rising edge.
    task automatic tick();
        int i;
        @(negedge clk);
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cyc) begin
                check_val(sb[i].tag, obs(sb[i].sel), sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic resolve(input logic [1:0] t, input logic [31:0] rpc, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                           input logic exp_fl, input logic [31:0] exp_pc);
        res_valid       = 1'b1;
        res_type        = t;
        res_pc          = rpc;
        res_taken       = tk;
        res_target      = tgt;
        res_pred_taken  = ptk;
        res_pred_target = ptgt;
        expect_at("flush", S_FL, 0, {31'd0, exp_fl});
        if (t != 2'b11) e_b++;
        if (exp_fl) begin
            e_m++;
            expect_at("redirect_pc", S_PC, 1, exp_pc);
        end
        expect_at("mispredict_cnt", S_MC, 1, e_m);
        expect_at("branch_cnt", S_BC, 1, e_b);
        tick();
        res_valid = 1'b0;
    endtask

    // Steer fetch to addr via a not-taken branch at addr-4 that was predicted
    // taken; a not-taken miss never allocates, so the BTB is untouched.
    task automatic redirect(input logic [31:0] addr);
        resolve(2'b00, addr - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, addr);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;

        // free run from reset
        expect_at("rst_mcnt", S_MC, 0, 0);
        expect_at("rst_bcnt", S_BC, 0, 0);
        for (int i = 0; i < 4; i++) begin
            expect_at("run_pc", S_PC, 0, 32'(4 * i));
            expect_at("run_pred", S_PT, 0, 0);
            expect_at("run_ptgt", S_PTG, 0, 32'(4 * i + 4));
            expect_at("run_flush", S_FL, 0, 0);
            tick();
        end

        // cold taken branch at 0x10
        expect_at("cold_pred", S_PT, 0, 0);
        resolve(2'b00, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14, 1'b1, 32'h40);
        redirect(32'h10);
        expect_at("alloc_pred", S_PT, 0, 1);
        expect_at("alloc_ptgt", S_PTG, 0, 32'h40);
        tick();

        // counter saturation and step-down
        for (int i = 0; i < 3; i++)
            resolve(2'b00, 32'h10, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0);
        resolve(2'b00, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h14);
        redirect(32'h10);
        expect_at("ctr10_pred", S_PT, 0, 1);
        tick();
        resolve(2'b00, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h14);
        redirect(32'h10);
        expect_at("ctr01_pred", S_PT, 0, 0);
        expect_at("ctr01_ptgt", S_PTG, 0, 32'h14);
        tick();

        // JALR target change
        resolve(2'b10, 32'h20, 1'b1, 32'h100, 1'b0, 32'h24, 1'b1, 32'h100);
        resolve(2'b10, 32'h20, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 32'h200);
        redirect(32'h20);
        expect_at("jalr_pred", S_PT, 0, 1);
        expect_at("jalr_ptgt", S_PTG, 0, 32'h200);
        tick();

        // reserved type: no flush, no count
        resolve(2'b11, 32'h30, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);

        // mispredict beats stall, then stall holds
        stall = 1'b1;
        resolve(2'b00, 32'h54, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h300);
        for (int i = 0; i < 3; i++) begin
            expect_at("stall_pc", S_PC, 0, 32'h300);
            tick();
        end
        stall = 1'b0;

        // PRED_EN=0 build never predicts
        resolve(2'b00, 32'h10, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0);
        redirect(32'h10);
        expect_at("pen1_pred", S_PT, 0, 1);
        expect_at("pen0_pred", S_PT0, 0, 0);
        expect_at("pen0_pc", S_PC0, 0, 32'h10);
        tick();

        // reset overrides a concurrent resolve
        rst             = 1'b1;
        res_valid       = 1'b1;
        res_type        = 2'b00;
        res_pc          = 32'h60;
        res_taken       = 1'b1;
        res_target      = 32'h400;
        res_pred_taken  = 1'b0;
        res_pred_target = 32'h0;
        tick();
        rst       = 1'b0;
        res_valid = 1'b0;
        e_m       = 0;
        e_b       = 0;
        expect_at("rst2_pc", S_PC, 0, 32'h0);
        expect_at("rst2_mcnt", S_MC, 0, 0);
        expect_at("rst2_bcnt", S_BC, 0, 0);
        expect_at("rst2_pred", S_PT, 0, 0);
        tick();
        redirect(32'h60);
        expect_at("rst_no_train", S_PT, 0, 0);
        tick();
        redirect(32'h10);
        expect_at("rst_cleared", S_PT, 0, 0);
        expect_at("rst_cleared_pc0", S_PC0, 0, 32'h10);
        tick();
        tick();

        check_val("scoreboard_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
